instruction_fetch: RTL and testbench

//  Fetch stage of the 8-bit lab5 core: owns the PC, issues one read at a time to instruction memory,
//  and holds the fetched byte stable for decode and immediate extraction until decode releases it.

---
 rtl/instruction_fetch.sv | 111 +++++++++++
 tb/tb_instruction_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing one imem read at a time and holding the fetched byte for decode.
// Define IFETCH_HALT_EN to stop fetching after a HALT_OPCODE byte is released, until pc_load.
module instruction_fetch #(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
`ifdef IFETCH_HALT_EN
  , parameter logic [7:0] HALT_OPCODE = 8'hFF
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd,
  input  logic [7:0]          imem_data,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                pc_load,
  input  logic                pc_rel,
  input  logic [PC_WIDTH-1:0] pc_target,
  input  logic [7:0]          pc_offset,
  output logic [7:0]          instruction,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr_pc
`ifdef IFETCH_HALT_EN
  , output logic              halted
`endif
);
  typedef enum logic [1:0] {
    FETCH, WAIT, HOLD
`ifdef IFETCH_HALT_EN
    , HALT
`endif
  } state_t;
  state_t state;
  logic [PC_WIDTH-1:0] pc, target;
  logic flush;
  always_comb target = pc_rel ? instr_pc + PC_WIDTH'($signed(pc_offset)) : pc_target;
  assign imem_addr = pc;
  // imem_rd low in FETCH only right after reset; every other entry into FETCH arms the strobe
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      imem_rd <= 1'b0;
      instruction <= 8'h00;
      instr_valid <= 1'b0;
      instr_pc <= '0;
      flush <= 1'b0;
`ifdef IFETCH_HALT_EN
      halted <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH:
          if (!imem_rd) begin
            imem_rd <= 1'b1;
            if (pc_load) pc <= target;
          end else begin
            imem_rd <= 1'b0;
            state <= WAIT;
            if (pc_load) begin
              pc <= target;
              flush <= 1'b1;
            end
          end
        WAIT:
          if (imem_valid && (pc_load || flush)) begin
            flush <= 1'b0;
            imem_rd <= 1'b1;
            state <= FETCH;
            if (pc_load) pc <= target;
          end else if (imem_valid) begin
            instruction <= imem_data;
            instr_pc <= pc;
            instr_valid <= 1'b1;
            pc <= pc + PC_WIDTH'(1);
            state <= HOLD;
          end else if (pc_load) begin
            pc <= target;
            flush <= 1'b1;
          end
        HOLD:
          if (pc_load) begin
            instr_valid <= 1'b0;
            pc <= target;
            imem_rd <= 1'b1;
            state <= FETCH;
`ifdef IFETCH_HALT_EN
          end else if (!stall && instruction == HALT_OPCODE) begin
            instr_valid <= 1'b0;
            halted <= 1'b1;
            state <= HALT;
`endif
          end else if (!stall) begin
            instr_valid <= 1'b0;
            imem_rd <= 1'b1;
            state <= FETCH;
          end
`ifdef IFETCH_HALT_EN
        HALT:
          if (pc_load) begin
            pc <= target;
            halted <= 1'b0;
            imem_rd <= 1'b1;
            state <= FETCH;
          end
`endif
        default: state <= FETCH;
      endcase
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed tests of instruction_fetch against a variable-latency memory model.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] imem_addr, imem_data, instruction, instr_pc, pc_target, pc_offset;
  logic imem_rd, imem_valid, instr_valid;
  logic stall = 1'b0, pc_load = 1'b0, pc_rel = 1'b0;
`ifdef IFETCH_HALT_EN
  logic halted;
`endif
  int errors = 0, checks = 0, lat = 1, cnt;
  logic [7:0] mem [256];
  logic [7:0] ma;

  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_valid(imem_valid), .stall(stall), .pc_load(pc_load),
    .pc_rel(pc_rel), .pc_target(pc_target), .pc_offset(pc_offset), .instruction(instruction),
    .instr_valid(instr_valid), .instr_pc(instr_pc)
`ifdef IFETCH_HALT_EN
    , .halted(halted)
`endif
  );

  always #5 clk = ~clk;

  // memory: response arrives lat cycles after the cycle imem_rd is high
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= 0;
      imem_valid <= 1'b0;
      imem_data <= 8'h00;
    end else begin
      imem_valid <= 1'b0;
      if (imem_rd) begin
        if (lat == 1) begin
          imem_valid <= 1'b1;
          imem_data <= mem[imem_addr];
        end else begin
          cnt <= lat - 1;
          ma <= imem_addr;
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          imem_valid <= 1'b1;
          imem_data <= mem[ma];
        end
      end
    end

  task step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pc_load = 1'b0;
    step(2);
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", imem_rd); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h want 00", instruction); end
    checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_ipc: got %h want 00", instr_pc); end
    reset_n = 1'b1;
  endtask

  task wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL valid_timeout: got %b want 1", instr_valid); end
  endtask

  task test_sequential();
    lat = 1; stall = 1'b0;
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      int ph, k;
      step();
      ph = (c - 1) % 3;
      k = (c - 1) / 3;
      checks++; if (imem_rd !== (ph == 0)) begin errors++; $display("FAIL seq_rd c=%0d: got %b want %b", c, imem_rd, ph == 0); end
      checks++; if (instr_valid !== (ph == 2)) begin errors++; $display("FAIL seq_valid c=%0d: got %b want %b", c, instr_valid, ph == 2); end
      if (ph == 0) begin
        checks++; if (imem_addr !== 8'(k)) begin errors++; $display("FAIL seq_addr c=%0d: got %h want %h", c, imem_addr, 8'(k)); end
      end
      if (ph == 2) begin
        checks++; if (instr_pc !== 8'(k)) begin errors++; $display("FAIL seq_ipc c=%0d: got %h want %h", c, instr_pc, 8'(k)); end
        checks++; if (instruction !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL seq_instr c=%0d: got %h want %h", c, instruction, 8'hA0 + 8'(k)); end
      end
    end
  endtask

  task test_stall();
    lat = 1; stall = 1'b1;
    mem[0] = 8'h3C;
    apply_reset();
    step(3);
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1 || instruction !== 8'h3C) begin errors++; $display("FAIL stall_hold i=%0d: got %b/%h want 1/3c", i, instr_valid, instruction); end
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL stall_rd i=%0d: got %b want 0", i, imem_rd); end
      if (i == 4) stall = 1'b0;
      step();
    end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", instr_valid); end
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h01) begin errors++; $display("FAIL stall_release_fetch: got %b/%h want 1/01", imem_rd, imem_addr); end
  endtask

  task redirect_hold(input logic rel, input logic [7:0] tgt, input logic [7:0] off, input logic [7:0] exp);
    pc_load = 1'b1; pc_rel = rel; pc_target = tgt; pc_offset = off;
    step();
    pc_load = 1'b0;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== exp) begin errors++; $display("FAIL redir_fetch: got %b/%h want 1/%h", imem_rd, imem_addr, exp); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", instr_valid); end
    step(2);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== exp) begin errors++; $display("FAIL redir_ipc: got %b/%h want 1/%h", instr_valid, instr_pc, exp); end
  endtask

  task test_relative();
    lat = 1; stall = 1'b1;
    apply_reset();
    pc_load = 1'b1; pc_rel = 1'b1; pc_offset = 8'h05;
    step();
    pc_load = 1'b0;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h05) begin errors++; $display("FAIL rel_after_reset: got %b/%h want 1/05", imem_rd, imem_addr); end
    step(2);
    checks++; if (instr_pc !== 8'h05) begin errors++; $display("FAIL rel_after_reset_ipc: got %h want 05", instr_pc); end
    redirect_hold(1'b0, 8'h10, 8'h00, 8'h10);
    redirect_hold(1'b1, 8'h00, 8'hFC, 8'h0C);
    redirect_hold(1'b0, 8'hF0, 8'h00, 8'hF0);
    redirect_hold(1'b1, 8'h00, 8'h7F, 8'h6F);
  endtask

  task test_redirect_wait();
    lat = 3; stall = 1'b1;
    mem[0] = 8'hEE; mem[8'h40] = 8'h55;
    apply_reset();
    step();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL wait_first_rd: got %b/%h want 1/00", imem_rd, imem_addr); end
    step();
    pc_load = 1'b1; pc_rel = 1'b0; pc_target = 8'h40;
    step();
    pc_load = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid_n3: got %b want 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b0 || imem_rd !== 1'b0) begin errors++; $display("FAIL wait_n4: got %b/%b want 0/0", instr_valid, imem_rd); end
    step();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_refetch: got %b/%h/%b want 1/40/0", imem_rd, imem_addr, instr_valid); end
    wait_valid();
    checks++; if (instr_pc !== 8'h40 || instruction !== 8'h55) begin errors++; $display("FAIL wait_result: got %h/%h want 40/55", instr_pc, instruction); end
  endtask

  task test_load_with_valid();
    lat = 3; stall = 1'b1;
    mem[0] = 8'hEE; mem[8'h20] = 8'h77;
    apply_reset();
    step(4);
    pc_load = 1'b1; pc_rel = 1'b0; pc_target = 8'h20;
    step();
    pc_load = 1'b0;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h20 || instr_valid !== 1'b0) begin errors++; $display("FAIL coll_refetch: got %b/%h/%b want 1/20/0", imem_rd, imem_addr, instr_valid); end
    wait_valid();
    checks++; if (instr_pc !== 8'h20 || instruction !== 8'h77) begin errors++; $display("FAIL coll_result: got %h/%h want 20/77", instr_pc, instruction); end
  endtask

  task test_reset_mid_wait();
    lat = 3; stall = 1'b1;
    mem[0] = 8'h11; mem[8'h30] = 8'h99;
    apply_reset();
    pc_load = 1'b1; pc_rel = 1'b0; pc_target = 8'h30;
    step();
    pc_load = 1'b0;
    checks++; if (imem_addr !== 8'h30) begin errors++; $display("FAIL mid_addr: got %h want 30", imem_addr); end
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h00 || imem_rd !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got %h/%b/%b want 00/0/0", imem_addr, imem_rd, instr_valid); end
    step(3);
    reset_n = 1'b1;
    step();
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_refetch: got %b/%h/%b want 1/00/0", imem_rd, imem_addr, instr_valid); end
    wait_valid();
    checks++; if (instr_pc !== 8'h00 || instruction !== 8'h11) begin errors++; $display("FAIL mid_result: got %h/%h want 00/11", instr_pc, instruction); end
  endtask

  task test_halt();
    lat = 1; stall = 1'b1;
    mem[5] = 8'hFF;
    apply_reset();
    step(3);
    pc_load = 1'b1; pc_rel = 1'b0; pc_target = 8'h05;
    step();
    pc_load = 1'b0;
    step(2);
    checks++; if (instr_valid !== 1'b1 || instruction !== 8'hFF || instr_pc !== 8'h05) begin errors++; $display("FAIL halt_present: got %b/%h/%h want 1/ff/05", instr_valid, instruction, instr_pc); end
    stall = 1'b0;
    step();
`ifdef IFETCH_HALT_EN
    begin
      logic saw_rd = 1'b0;
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: got %b/%b want 1/0", halted, instr_valid); end
      for (int i = 0; i < 20; i++) begin
        step();
        if (imem_rd) saw_rd = 1'b1;
      end
      checks++; if (saw_rd !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_idle: got rd=%b halted=%b want 0/1", saw_rd, halted); end
      pc_load = 1'b1; pc_target = 8'h00;
      step();
      pc_load = 1'b0;
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00 || halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got %b/%h/%b want 1/00/0", imem_rd, imem_addr, halted); end
    end
`else
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h06 || instr_valid !== 1'b0) begin errors++; $display("FAIL ff_ordinary: got %b/%h/%b want 1/06/0", imem_rd, imem_addr, instr_valid); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    pc_target = 8'h00;
    pc_offset = 8'h00;
    test_sequential();
    test_stall();
    test_relative();
    test_redirect_wait();
    test_load_with_valid();
    test_reset_mid_wait();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
